// File: rtl/display_scheduler.sv
// Time-multiplexing scheduler for a shared seven-segment decoder: one digit slot at a time,
// with blanking dead-time before each slot and frame-atomic digit value updates.
module display_scheduler #(
    parameter int NDIG  = 2,
    parameter int DWELL = 12000,
    parameter int BLANK = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] digits_in,
    input  logic              load,
    input  logic [NDIG-1:0]   digit_en,
    output logic [3:0]        hex,
    output logic [NDIG-1:0]   t,
    output logic              frame_start,
    output logic              dbg_state
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC);
    localparam int IW   = $clog2(NDIG);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic [4*NDIG-1:0]   staging_q;
    logic [4*NDIG-1:0]   shadow_q;
    logic                pending_q;
    logic [3:0]          hex_q;
    logic [3:0]          nib_d;
    logic [NDIG-1:0]     t_q;
    logic [NDIG-1:0]     sel_d;
    logic                fs_q;
    logic                drive_end;
    logic                wrap;

    // load is a plain single-cycle strobe: no ready/ack, every pulse is taken.
    always_comb begin
        nib_d = '0;
        sel_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                nib_d    = shadow_q[i*4 +: 4];
                sel_d[i] = digit_en[i];
            end
        end
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    assign drive_end = (state_q == ST_DRIVE) && (cnt_q == DWELL_LAST);
    assign wrap      = drive_end && (idx_q == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= '0;
            t_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            case (state_q)
                ST_BLANK: begin
                    hex_q <= nib_d;
                    if (cnt_q == BLANK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRIVE;
                        t_q     <= sel_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (drive_end) begin
                        cnt_q   <= '0;
                        t_q     <= '0;
                        state_q <= ST_BLANK;
                        idx_q   <= idx_d;
                        fs_q    <= (idx_q == IDX_LAST);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_BLANK;
            endcase

            // A load landing on the wrap edge goes straight to the shadow copy.
            if (wrap) begin
                pending_q <= 1'b0;
                if (load) begin
                    shadow_q <= digits_in;
                end else if (pending_q) begin
                    shadow_q <= staging_q;
                end
            end else if (load) begin
                staging_q <= digits_in;
                pending_q <= 1'b1;
            end
        end
    end

    assign hex         = hex_q;
    assign t           = t_q;
    assign frame_start = fs_q;
    assign dbg_state   = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with NDIG=2, DWELL=4, BLANK=2: per-cycle vector table plus
// hand-written sequences for the all-disabled frame period and a load seen with selects off.
module tb_display_scheduler;

    localparam int NV = 103;
    localparam int RST_CYC = 76;

    logic       clk;
    logic       reset;
    logic [7:0] digits_in;
    logic       load;
    logic [1:0] digit_en;
    logic [3:0] hex;
    logic [1:0] t;
    logic       frame_start;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] din;
        logic [1:0] en;
        logic [1:0] t;
        logic [3:0] hex;
        logic       fs;
        logic       st;
    } vec_t;

    vec_t       vec [NV];
    logic [7:0] sh  [7];

    display_scheduler #(.NDIG(2), .DWELL(4), .BLANK(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .load        (load),
        .digit_en    (digit_en),
        .hex         (hex),
        .t           (t),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gap;
        logic seen;

        // Shadow contents in effect during each frame of the first epoch.
        sh[0] = 8'h00; sh[1] = 8'hA5; sh[2] = 8'hA5; sh[3] = 8'h3C;
        sh[4] = 8'h3C; sh[5] = 8'h34; sh[6] = 8'h34;

        for (int c = 0; c < NV; c++) begin
            int         rc;
            int         f;
            int         k;
            logic [7:0] cur;
            logic [7:0] prev;
            logic [1:0] en;
            rc   = (c <= RST_CYC) ? c : c - (RST_CYC + 1);
            f    = rc % 12;
            k    = rc / 12;
            cur  = (c <= RST_CYC) ? sh[k] : 8'h00;
            prev = (c <= RST_CYC && k > 0) ? sh[k-1] : 8'h00;
            en   = (c >= 24 && c < 48) ? 2'b01 : 2'b11;
            vec[c].rst = 1'b0;
            vec[c].ld  = 1'b0;
            vec[c].din = 8'($urandom);
            vec[c].en  = en;
            vec[c].t   = (f >= 2 && f <= 5) ? {1'b0, en[0]} : (f >= 8) ? {en[1], 1'b0} : 2'b00;
            vec[c].hex = (f == 0) ? prev[7:4] : (f <= 6) ? cur[3:0] : cur[7:4];
            vec[c].fs  = (f == 0) && (k > 0);
            vec[c].st  = (f >= 2 && f <= 5) || (f >= 8);
        end
        vec[3].ld  = 1'b1; vec[3].din  = 8'hA5;
        vec[35].ld = 1'b1; vec[35].din = 8'h3C;
        vec[49].ld = 1'b1; vec[49].din = 8'h12;
        vec[55].ld = 1'b1; vec[55].din = 8'h34;
        vec[73].ld = 1'b1; vec[73].din = 8'hA5;
        vec[RST_CYC].rst = 1'b1;

        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 8'h00;
        digit_en  = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_t",  -1, 32'(t), 32'h0);
        check("rst_hex", -1, 32'(hex), 32'h0);
        check("rst_fs", -1, 32'(frame_start), 32'h0);
        check("rst_st", -1, 32'(dbg_state), 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            check("t",   i, 32'(t),           32'(vec[i].t));
            check("hex", i, 32'(hex),         32'(vec[i].hex));
            check("fs",  i, 32'(frame_start), 32'(vec[i].fs));
            check("st",  i, 32'(dbg_state),   32'(vec[i].st));
            reset     = vec[i].rst;
            load      = vec[i].ld;
            digits_in = vec[i].din;
            digit_en  = vec[i].en;
        end

        // All digits disabled: frame period must stay 12 and no select may rise.
        load     = 1'b0;
        digit_en = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        check("fs_found", -1, 32'(seen), 32'h1);

        load      = 1'b1;
        digits_in = 8'h7E;
        gap  = 0;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            load = 1'b0;
            gap++;
            check("t_en00", n, 32'(t), 32'h0);
            if (frame_start) seen = 1'b1;
        end
        check("frame_period", -1, 32'(gap), 32'd12);

        repeat (3) @(negedge clk);
        check("hex_slot0_en00", -1, 32'(hex), 32'hE);
        check("t_slot0_en00", -1, 32'(t), 32'h0);
        repeat (6) @(negedge clk);
        check("hex_slot1_en00", -1, 32'(hex), 32'h7);
        check("t_slot1_en00", -1, 32'(t), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
